// File: rtl/mul5bcd_seq.sv
// Serial BCD x5 multiplier: emits one product digit per clock, LSD first.
// Optional macro MUL5BCD_EARLY_EXIT_EN ends the run once the remaining digits are all zero.
module mul5bcd_seq #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [4*NDIG-1:0] op,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [4*NDIG+3:0] prod,
    output logic              err
);

    localparam int IW = $clog2(NDIG + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [3:0]        prev_q, prev_d;
    logic [4*NDIG-1:0] opnd_q, opnd_d;
    logic [4*NDIG+3:0] prod_q, prod_d;
    logic              err_q, err_d;

    logic [3:0]        dig;
    logic [3:0]        new_digit;
    logic              last;
    logic              exit_now;
`ifdef MUL5BCD_EARLY_EXIT_EN
    logic              tail_zero;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            prev_q  <= '0;
            opnd_q  <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            opnd_q  <= opnd_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
        end
    end

    // Operand digit at the current index; reads as 0 at index NDIG so the top
    // product digit falls out of the same formula as prev/2.
    always_comb begin
        dig = 4'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (idx_q == IW'(i)) dig = opnd_q[4*i +: 4];
        end
        new_digit = (dig[0] ? 4'd5 : 4'd0) + {1'b0, prev_q[3:1]};
        last      = (idx_q == IW'(NDIG));
    end

`ifdef MUL5BCD_EARLY_EXIT_EN
    always_comb begin
        tail_zero = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if ((IW'(i) >= idx_q) && (opnd_q[4*i +: 4] != 4'd0)) tail_zero = 1'b0;
        end
        exit_now = tail_zero && (prev_q < 4'd2);
    end
`else
    assign exit_now = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        prev_d  = prev_q;
        opnd_d  = opnd_q;
        prod_d  = prod_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d  = op;
                    prod_d  = '0;
                    err_d   = 1'b0;
                    prev_d  = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (exit_now) begin
                    state_d = DONE;
                    if (err_q) prod_d = '0;
                end else begin
                    for (int i = 0; i <= NDIG; i++) begin
                        if (idx_q == IW'(i)) prod_d[4*i +: 4] = new_digit;
                    end
                    if (last) begin
                        state_d = DONE;
                        if (err_q) prod_d = '0;
                    end else begin
                        if (dig > 4'd9) err_d = 1'b1;
                        prev_d = dig;
                        idx_d  = idx_q + IW'(1);
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign prod  = prod_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mul5bcd_seq.sv
// Self-checking bench for mul5bcd_seq: directed cases plus randomized operands
// against a decimal-arithmetic reference model.
module tb_mul5bcd_seq;

    localparam int NDIG = 4;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [4*NDIG-1:0] op;
    logic              ready, busy, done, err;
    logic [4*NDIG+3:0] prod;

    int n_cmp = 0;
    int n_mis = 0;

    mul5bcd_seq #(.NDIG(NDIG)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .ready(ready), .busy(busy), .done(done), .prod(prod), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Product, error flag and cycles-to-done computed from the decimal value.
    function automatic void ref_model(input logic [4*NDIG-1:0] v_op,
                                      output logic [4*NDIG+3:0] p,
                                      output logic e, output int lat);
        longint v = 0;
        logic [3:0] d;
        e = 1'b0;
        p = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            d = v_op[4*i +: 4];
            if (d > 4'd9) e = 1'b1;
            v = v * 10 + longint'(d);
        end
        v = v * 5;
        for (int i = 0; i <= NDIG; i++) begin
            p[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        if (e) p = '0;
        lat = NDIG + 2;
`ifdef MUL5BCD_EARLY_EXIT_EN
        begin
            int m = NDIG + 1;
            for (int k = NDIG; k >= 0; k--) begin
                bit zero_tail = 1'b1;
                int prev = (k == 0) ? 0 : int'(v_op[4*(k-1) +: 4]);
                for (int j = k; j < NDIG; j++)
                    if (v_op[4*j +: 4] != 4'd0) zero_tail = 1'b0;
                if (zero_tail && prev < 2) m = k;
            end
            lat = m + 2;
        end
`endif
    endfunction

    task automatic applyStimulus(input logic [4*NDIG-1:0] op_in, input bit inject, input string tag);
        logic [4*NDIG+3:0] exp_p;
        logic exp_e;
        int exp_lat, edges, busy_cnt, w;
        logic [4*NDIG+3:0] held;
        ref_model(op_in, exp_p, exp_e, exp_lat);
        w = 0;
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        start = 1'b1;
        op    = op_in;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = 16'($urandom);
        edges = 1;
        busy_cnt = 0;
        while (!done && edges < 4 * NDIG + 10) begin
            if (busy) busy_cnt++;
            if (inject && edges == 2) begin
                start = 1'b1;
                op    = {NDIG{4'h5}};
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        if (!done) begin
            checkOutput({tag, "_timeout"}, 64'(done), 64'd1);
        end else begin
            checkOutput({tag, "_latency"}, 64'(edges), 64'(exp_lat));
            checkOutput({tag, "_prod"}, 64'(prod), 64'(exp_p));
            checkOutput({tag, "_err"}, 64'(err), 64'(exp_e));
            checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat - 1));
            held = prod;
            @(negedge clk);
            checkOutput({tag, "_done_pulse"}, 64'(done), 64'd0);
            checkOutput({tag, "_ready_after"}, 64'(ready), 64'd1);
            checkOutput({tag, "_prod_hold"}, 64'(prod), 64'(exp_p));
            checkOutput({tag, "_err_hold"}, 64'(err), 64'(exp_e));
            if (held !== exp_p) checkOutput({tag, "_prod_at_done"}, 64'(held), 64'(exp_p));
        end
    endtask

    initial begin
        logic [4*NDIG+3:0] exp_p;
        logic exp_e;
        int exp_lat, w, gap, done_seen;
        logic [4*NDIG-1:0] r_op;

        rst_n = 1'b0;
        start = 1'b0;
        op    = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 64'(ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_prod", 64'(prod), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(16'h1234, 1'b0, "op1234");
        applyStimulus(16'h9999, 1'b0, "op9999");
        applyStimulus(16'h12A4, 1'b0, "op12A4");
        applyStimulus(16'h0001, 1'b0, "op0001");
        applyStimulus(16'h0002, 1'b1, "ignored_start");
        applyStimulus(16'h0013, 1'b0, "op0013");
        applyStimulus(16'h0000, 1'b0, "op0000");

        // Reset in the middle of an operation, at digit index 2.
        start = 1'b1;
        op    = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ready", 64'(ready), 64'd1);
        checkOutput("midrst_busy", 64'(busy), 64'd0);
        checkOutput("midrst_prod", 64'(prod), 64'd0);
        checkOutput("midrst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("midrst_no_done", 64'(done_seen), 64'd0);
        applyStimulus(16'h0007, 1'b0, "after_rst");

        // Start held high: the next operation begins on the IDLE cycle after DONE.
        ref_model(16'h9999, exp_p, exp_e, exp_lat);
        start = 1'b1;
        op    = 16'h9999;
        w = 0;
        while (!done && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("held_first_done", 64'(done), 64'd1);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!done && gap < 50);
        start = 1'b0;
        checkOutput("held_gap", 64'(gap), 64'(exp_lat + 1));
        checkOutput("held_prod", 64'(prod), 64'(exp_p));
        @(negedge clk);

        for (int n = 0; n < 24; n++) begin
            int nz;
            nz = int'($urandom_range(0, NDIG));
            for (int i = 0; i < NDIG; i++) begin
                if (i >= nz && ($urandom_range(0, 1) == 0)) r_op[4*i +: 4] = 4'd0;
                else if ($urandom_range(0, 7) == 0) r_op[4*i +: 4] = 4'($urandom_range(10, 15));
                else r_op[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            applyStimulus(r_op, ($urandom_range(0, 3) == 0), $sformatf("rand%0d_%h", n, r_op));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
